// File: rtl/axi_rb_burst_reader_pkg.sv
// rtl/axi_rb_burst_reader_pkg.sv - shared types and constants for the burst reader
// Purpose: FSM state enum, fixed AXI read-address field values and the
//          beat-count helper used by axi_rb_burst_reader.
// Ports:   none (package).
package axi_rb_burst_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_W    = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  // A programmed length of zero still moves one beat.
  function automatic logic [7:0] beat_count(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

endpackage

// File: rtl/add.sv
// rtl/add.sv - combinational adder primitive
// Purpose: y = a + b, truncated to WIDTH bits.
// Ports:   a, b (in WIDTH) operands; y (out WIDTH) sum.
module add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a + b;

endmodule

// File: rtl/br_dummy.sv
// rtl/br_dummy.sv - no-op control marker primitive
// Purpose: empty marker instance at a control boundary; carries no logic.
// Ports:   none.
module br_dummy;
endmodule

// File: rtl/axi_rb_burst_reader.sv
// rtl/axi_rb_burst_reader.sv - single INCR AXI4 read burst forwarded beat by beat into a FIFO
// Purpose: captures base address (arg_2) and beat count (arg_1), issues one
//          AXI read burst on arg_3, writes each returned beat to the FIFO on
//          arg_0, then holds valid high until rst.
// Ports:   clk, rst (sync, active-high);
//          arg_3_s_axi_ar*/r* AXI read channel, aw*/w*/b* tied off;
//          arg_0_* FIFO write port (read side tied off);
//          arg_2_* address memory, arg_1_* length memory (read port at 0);
//          valid done flag.
module axi_rb_burst_reader
  import axi_rb_burst_reader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] arg_3_s_axi_araddr,
  output logic [1:0]  arg_3_s_axi_arburst,
  output logic [7:0]  arg_3_s_axi_arlen,
  output logic [2:0]  arg_3_s_axi_arsize,
  output logic        arg_3_s_axi_arvalid,
  input  logic        arg_3_s_axi_arready,
  input  logic [31:0] arg_3_s_axi_rdata,
  input  logic        arg_3_s_axi_rvalid,
  output logic        arg_3_s_axi_rready,
  output logic [15:0] arg_3_s_axi_awaddr,
  output logic [1:0]  arg_3_s_axi_awburst,
  output logic [7:0]  arg_3_s_axi_awlen,
  output logic [2:0]  arg_3_s_axi_awsize,
  output logic        arg_3_s_axi_awvalid,
  input  logic        arg_3_s_axi_awready,
  output logic [31:0] arg_3_s_axi_wdata,
  output logic [3:0]  arg_3_s_axi_wstrb,
  output logic        arg_3_s_axi_wvalid,
  input  logic        arg_3_s_axi_wready,
  input  logic        arg_3_s_axi_bvalid,
  output logic        arg_3_s_axi_bready,
  output logic [31:0] arg_0_in_data,
  output logic        arg_0_write_valid,
  input  logic        arg_0_write_ready,
  input  logic [31:0] arg_0_out_data,
  output logic        arg_0_read_valid,
  input  logic        arg_0_read_ready,
  output logic [15:0] arg_2_raddr,
  input  logic [15:0] arg_2_rdata,
  output logic [15:0] arg_2_waddr,
  output logic [15:0] arg_2_wdata,
  output logic        arg_2_wen,
  output logic [7:0]  arg_1_raddr,
  input  logic [7:0]  arg_1_rdata,
  output logic [7:0]  arg_1_waddr,
  output logic [7:0]  arg_1_wdata,
  output logic        arg_1_wen,
  output logic        valid
);

  state_t      state_q, state_d;
  logic [15:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  i_q;
  logic [7:0]  i_next;
  logic [31:0] data_q;
  logic [7:0]  cnt;

  assign cnt = beat_count(len_q);

  add #(.WIDTH(8)) u_beat_add (
    .a (i_q),
    .b (8'd1),
    .y (i_next)
  );

  br_dummy u_br_dummy ();

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers; i counts beats already accepted from the slave.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      len_q  <= '0;
      i_q    <= '0;
      data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          addr_q <= arg_2_rdata;
          len_q  <= arg_1_rdata;
          i_q    <= '0;
        end
        ST_R: begin
          if (arg_3_s_axi_rvalid) begin
            data_q <= arg_3_s_axi_rdata;
            i_q    <= i_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_AR;
      ST_AR:   if (arg_3_s_axi_arready) state_d = ST_R;
      ST_R:    if (arg_3_s_axi_rvalid)  state_d = ST_W;
      ST_W:    if (arg_0_write_ready)   state_d = (i_q < cnt) ? ST_R : ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs depend on state only, never on their own ready.
  always_comb begin
    arg_3_s_axi_arvalid = 1'b0;
    arg_3_s_axi_rready  = 1'b0;
    arg_0_write_valid   = 1'b0;
    valid               = 1'b0;
    case (state_q)
      ST_AR:   arg_3_s_axi_arvalid = 1'b1;
      ST_R:    arg_3_s_axi_rready  = 1'b1;
      ST_W:    arg_0_write_valid   = 1'b1;
      ST_DONE: valid               = 1'b1;
      default: ;
    endcase
  end

  assign arg_3_s_axi_araddr  = addr_q;
  assign arg_3_s_axi_arlen   = cnt - 8'd1;
  assign arg_3_s_axi_arburst = AXI_BURST_INCR;
  assign arg_3_s_axi_arsize  = AXI_SIZE_4B;
  assign arg_0_in_data       = data_q;

  assign arg_3_s_axi_awaddr  = '0;
  assign arg_3_s_axi_awburst = '0;
  assign arg_3_s_axi_awlen   = '0;
  assign arg_3_s_axi_awsize  = '0;
  assign arg_3_s_axi_awvalid = 1'b0;
  assign arg_3_s_axi_wdata   = '0;
  assign arg_3_s_axi_wstrb   = '0;
  assign arg_3_s_axi_wvalid  = 1'b0;
  assign arg_3_s_axi_bready  = 1'b0;
  assign arg_0_read_valid    = 1'b0;
  assign arg_2_raddr         = '0;
  assign arg_2_waddr         = '0;
  assign arg_2_wdata         = '0;
  assign arg_2_wen           = 1'b0;
  assign arg_1_raddr         = '0;
  assign arg_1_waddr         = '0;
  assign arg_1_wdata         = '0;
  assign arg_1_wen           = 1'b0;

  // Inputs of the unused write/read-back channels.
  logic unused_inputs;
  assign unused_inputs = ^{arg_3_s_axi_awready, arg_3_s_axi_wready,
                           arg_3_s_axi_bvalid, arg_0_out_data, arg_0_read_ready};

endmodule

// File: tb/tb_axi_rb_burst_reader.sv
// tb/tb_axi_rb_burst_reader.sv - self-checking bench for axi_rb_burst_reader
module tb_axi_rb_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] araddr;
  logic [1:0]  arburst;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [15:0] awaddr;
  logic [1:0]  awburst;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        bready;
  logic [31:0] in_data;
  logic        write_valid;
  logic        write_ready = 1'b1;
  logic        read_valid;
  logic [15:0] m2_raddr, m2_waddr, m2_wdata;
  logic        m2_wen;
  logic [15:0] m2_rdata = '0;
  logic [7:0]  m1_raddr, m1_waddr, m1_wdata;
  logic        m1_wen;
  logic [7:0]  m1_rdata = '0;
  logic        valid;

  axi_rb_burst_reader dut (
    .clk(clk), .rst(rst),
    .arg_3_s_axi_araddr(araddr), .arg_3_s_axi_arburst(arburst),
    .arg_3_s_axi_arlen(arlen), .arg_3_s_axi_arsize(arsize),
    .arg_3_s_axi_arvalid(arvalid), .arg_3_s_axi_arready(arready),
    .arg_3_s_axi_rdata(rdata), .arg_3_s_axi_rvalid(rvalid),
    .arg_3_s_axi_rready(rready),
    .arg_3_s_axi_awaddr(awaddr), .arg_3_s_axi_awburst(awburst),
    .arg_3_s_axi_awlen(awlen), .arg_3_s_axi_awsize(awsize),
    .arg_3_s_axi_awvalid(awvalid), .arg_3_s_axi_awready(1'b0),
    .arg_3_s_axi_wdata(wdata), .arg_3_s_axi_wstrb(wstrb),
    .arg_3_s_axi_wvalid(wvalid), .arg_3_s_axi_wready(1'b0),
    .arg_3_s_axi_bvalid(1'b0), .arg_3_s_axi_bready(bready),
    .arg_0_in_data(in_data), .arg_0_write_valid(write_valid),
    .arg_0_write_ready(write_ready), .arg_0_out_data(32'h0),
    .arg_0_read_valid(read_valid), .arg_0_read_ready(1'b0),
    .arg_2_raddr(m2_raddr), .arg_2_rdata(m2_rdata),
    .arg_2_waddr(m2_waddr), .arg_2_wdata(m2_wdata), .arg_2_wen(m2_wen),
    .arg_1_raddr(m1_raddr), .arg_1_rdata(m1_rdata),
    .arg_1_waddr(m1_waddr), .arg_1_wdata(m1_wdata), .arg_1_wen(m1_wen),
    .valid(valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the burst must deliver exactly the beats the slave
  // returned, in order, once each; the AR request must carry the captured
  // address and (max(len,1) - 1).
  logic [31:0] beats [256];
  int          n_beats;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [15:0] exp_addr;
  logic [7:0]  exp_arlen;
  int          ar_count;
  logic [7:0]  seen_arlen;

  // Compare process: runs 2 time units after each falling edge.
  bit          rst_seen = 1'b0;
  bit          ar_hold = 1'b0, w_hold = 1'b0, r_hold = 1'b0;
  logic [15:0] prev_araddr;
  logic [31:0] prev_in_data;

  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      rst_seen = 1'b1;
      ar_hold  = 1'b0;
      w_hold   = 1'b0;
      r_hold   = 1'b0;
    end else begin
      chk("tied_outputs", 32'(|{awaddr, awburst, awlen, awsize, awvalid, wdata, wstrb,
                                wvalid, bready, read_valid, m2_raddr, m2_waddr, m2_wdata,
                                m2_wen, m1_raddr, m1_waddr, m1_wdata, m1_wen}), 32'd0);
      if (rst_seen)
        chk("valids_after_rst", {28'd0, arvalid, rready, write_valid, valid}, 32'd0);
      rst_seen = 1'b0;
      chk("done_flag", 32'(valid), 32'(exp_q.size() == 0));
      if (ar_hold) begin
        chk("arvalid_held", 32'(arvalid), 32'd1);
        chk("araddr_held", 32'(araddr), 32'(prev_araddr));
      end
      if (w_hold) begin
        chk("wvalid_held", 32'(write_valid), 32'd1);
        chk("in_data_held", in_data, prev_in_data);
      end
      if (r_hold) chk("rready_held", 32'(rready), 32'd1);
      if (arvalid) begin
        chk("ar_once", ar_count, 32'd0);
        chk("araddr", 32'(araddr), 32'(exp_addr));
        chk("arlen", 32'(arlen), 32'(exp_arlen));
        chk("arsize", 32'(arsize), 32'd2);
        chk("arburst", 32'(arburst), 32'd1);
        seen_arlen = arlen;
      end
      if (write_valid) begin
        chk("rready_low_in_w", 32'(rready), 32'd0);
        chk("fifo_extra_write", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("fifo_data", in_data, exp_q[0]);
      end
      ar_hold      = arvalid && !arready;
      w_hold       = write_valid && !write_ready;
      r_hold       = rready && !rvalid;
      prev_araddr  = araddr;
      prev_in_data = in_data;
      if (arvalid && arready) ar_count++;
      if (write_valid && write_ready) begin
        got_q.push_back(in_data);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic load_model(input logic [15:0] addr, input logic [7:0] len);
    exp_q.delete();
    got_q.delete();
    for (int k = 0; k < n_beats; k++) exp_q.push_back(beats[k]);
    exp_addr  = addr;
    exp_arlen = 8'(((len == 8'd0) ? 1 : int'(len)) - 1);
    ar_count  = 0;
  endtask

  // Driver / AXI slave / FIFO sink. Inputs change 1 unit after the falling
  // edge; handshakes are sampled 4 units after it, ahead of the rising edge.
  task automatic run_test(input logic [15:0] addr, input logic [7:0] len,
                          input logic [31:0] dbase, input int ar_stall,
                          input int r_gap, input int ws_beat, input int ws_cycles,
                          input int rst_beat, output int done_edge);
    int beat_idx, gap, writes, wleft, budget;
    bit did_rst;
    n_beats = (len == 8'd0) ? 1 : int'(len);
    for (int k = 0; k < n_beats; k++) beats[k] = dbase + 32'(k);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    m2_rdata = addr;
    m1_rdata = len;
    load_model(addr, len);
    beat_idx = 0; gap = 0; writes = 0; wleft = ws_cycles; did_rst = 1'b0;
    done_edge = -1;
    budget = 2 * n_beats * (r_gap + 2) + ar_stall + 40;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      #1;
      if (rst && k > 1) begin
        rst = 1'b0;
        load_model(addr, len);
        beat_idx = 0; gap = 0; writes = 0; wleft = ws_cycles;
      end else if (k == 1) begin
        rst = 1'b0;
      end else if (!did_rst && rst_beat >= 0 && writes == rst_beat && rready) begin
        rst = 1'b1;
        did_rst = 1'b1;
      end
      if (valid && done_edge < 0) done_edge = k - 1;
      if (done_edge >= 0 && k >= done_edge + 4) break;
      arready = (k > ar_stall + 1);
      rvalid  = !rst && (beat_idx < n_beats) && (gap == 0);
      rdata   = rvalid ? beats[beat_idx] : 32'hDEAD_0000 + 32'(k);
      if (write_valid && writes == ws_beat && wleft > 0) begin
        write_ready = 1'b0;
        wleft--;
      end else begin
        write_ready = 1'b1;
      end
      #3;
      if (!rst) begin
        if (rvalid && rready) begin
          beat_idx++;
          gap = r_gap;
        end else if (gap > 0) begin
          gap--;
        end
        if (write_valid && write_ready) writes++;
      end
    end
    chk("timeout", 32'(done_edge >= 0), 32'd1);
    chk("all_beats_written", 32'(exp_q.size()), 32'd0);
    chk("write_count", 32'(got_q.size()), 32'(n_beats));
    rst = 1'b1;
  endtask

  int de;

  initial begin
    // Basic burst: hand-computed latency and payload.
    run_test(16'h1000, 8'd4, 32'hA0, 0, 0, -1, 0, -1, de);
    chk("t1_valid_cycle", de, 32'd10);
    chk("t1_arlen_lit", 32'(seen_arlen), 32'd3);
    for (int k = 0; k < 4; k++) chk("t1_fifo_lit", got_q[k], 32'hA0 + 32'(k));
    // AR back-pressure.
    run_test(16'h2468, 8'd4, 32'hB000_0000, 5, 0, -1, 0, -1, de);
    chk("t2_valid_cycle", de, 32'd15);
    chk("t2_fifo_last_lit", got_q[3], 32'hB000_0003);
    // rvalid gaps of 3 cycles.
    run_test(16'h3000, 8'd5, 32'hC0C0_0010, 0, 3, -1, 0, -1, de);
    chk("t3_fifo_lit", got_q[4], 32'hC0C0_0014);
    // FIFO stall on the second beat.
    run_test(16'h4321, 8'd4, 32'h1234_5670, 0, 0, 1, 4, -1, de);
    chk("t4_valid_cycle", de, 32'd14);
    // Zero length means one beat.
    run_test(16'hFFFC, 8'd0, 32'h5555_AAAA, 0, 0, -1, 0, -1, de);
    chk("t5_arlen_lit", 32'(seen_arlen), 32'd0);
    chk("t5_valid_cycle", de, 32'd4);
    // Reset after the first beat, then a full fresh burst.
    run_test(16'h0ABC, 8'd3, 32'h7700_0000, 0, 0, -1, 0, 1, de);
    chk("t6_fifo_first_lit", got_q[0], 32'h7700_0000);
    // Maximum length.
    run_test(16'h8000, 8'd255, 32'h0001_0000, 1, 0, -1, 0, -1, de);
    chk("t7_arlen_lit", 32'(seen_arlen), 32'd254);
    chk("t7_fifo_last_lit", got_q[254], 32'h0001_00FE);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
